fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage directly upstream of InstructionMemory.
//  - Owns the program counter and drives it to the memory's pc input.
//  - Captures the returned 16-bit instruction into an IF/ID pipeline register.
//  - Presents that register to decode through a valid/ready handshake.
//  - Handles stalls, branch/jump redirects (flush) and HALT detection.
// PARAMETERS
//  RESET_PC     16'h0000  PC value loaded on reset
//  HALT_OPCODE  4'hF      value of ins[15:12] that marks a HALT instruction
// PORTS
//  clk             in   1   single clock, all state updates on posedge
//  rst_n           in   1   reset, synchronous, active-low
//  imem_pc         out  16  address to InstructionMemory pc (word-addressed)
//  imem_ins        in   16  instruction from InstructionMemory, combinational, same cycle
//  redirect_valid  in   1   branch/jump taken this cycle
//  redirect_pc     in   16  target PC, sampled when redirect_valid=1
//  id_valid        out  1   IF/ID register holds a valid instruction
//  id_ready        in   1   decode accepts id_* this cycle
//  id_ins          out  16  fetched instruction
//  id_pc           out  16  PC the instruction was fetched from
//  halted          out  1   HALT has been fetched; fetch stopped
//  fetch_count     out  16  number of instructions fetched; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rst_n=0 at posedge)
//  - pc=RESET_PC, id_valid=0, id_ins=0, id_pc=0, halted=0, fetch_count=0, state=RUN.
//  - Reset beats every other input.
//  PC output
//  - imem_pc is the pc register, driven continuously.
//  Latency
//  - The instruction at pc appears on id_ins/id_pc at the next posedge.
//  - 1-cycle latency; throughput 1 instruction per cycle when id_ready=1.
//  Fetch fire
//  - fire = (state==RUN) && (!id_valid || id_ready) && !redirect_valid.
//  - On fire: id_ins<=imem_ins, id_pc<=pc, id_valid<=1, fetch_count<=sat(fetch_count+1).
//  - On fire, pc<=pc+1, with 16-bit wrap-around (16'hFFFF -> 16'h0000).
//  - Exception: if imem_ins[15:12]==HALT_OPCODE, pc holds and state<=HALTED.
//  Handshake
//  - Stall: id_valid=1 and id_ready=0 holds pc and all id_* outputs stable, with no fetch.
//  - If id_ready=1 while id_valid=1 and there is no fire, id_valid<=0.
//  State machine, 2 states
//  - RUN: fetch per the rules above. RUN->HALTED on a fired HALT.
//  - HALTED: halted=1; pc frozen at the HALT address; no fetch.
//  - In HALTED the HALT instruction itself is still delivered; id_valid clears once accepted.
//  - HALTED->RUN only via redirect.
//  Redirect (priority over fire and stall)
//  - pc<=redirect_pc, id_valid<=0 (held instruction discarded), state<=RUN, halted<=0.
//  - fetch_count is unchanged in the redirect cycle.
//  - The first instruction from the target appears one cycle later.
//  Boundary rules
//  - Redirect while stalled: the flush still occurs; id_ready is ignored that cycle.
//  - Redirect to the current pc is legal and simply refetches.
//  - Reset mid-stall or mid-HALT returns all outputs to their reset values.
//  - id_ins and id_pc are don't-care while id_valid=0 but must not change during a stall.
// TESTING
//  1. Stream: memory returns {4'h1,pc[11:0]}, reset, then id_ready=1.
//     -> id_valid=1 from the first posedge after reset.
//     -> id_pc = 0,1,2,3 on consecutive cycles; id_ins = 16'h1000..16'h1003.
//  2. Stall: id_ready=0 for 3 cycles while id_pc=2.
//     -> id_pc=2, id_ins=16'h1002, imem_pc=3 and fetch_count stay stable.
//     -> After release, id_pc=3 on the next cycle.
//  3. Redirect during a stall: redirect_valid=1, redirect_pc=16'h0010.
//     -> Next cycle: id_valid=0, imem_pc=16'h0010.
//     -> Cycle after: id_pc=16'h0010, id_valid=1.
//  4. Wrap: redirect to 16'hFFFF with id_ready=1.
//     -> id_pc=16'hFFFF, then id_pc=16'h0000.
//  5. Halt: memory returns 16'hF000 at pc=5.
//     -> id_pc=5, id_ins=16'hF000, halted=1, imem_pc stays 5, fetch_count frozen.
//     -> id_valid=0 after acceptance.
//     -> Redirect to 0 clears halted and resumes with id_pc=0.
//  6. Reset mid-stall: rst_n=0 for one cycle.
//     -> id_valid=0, halted=0, fetch_count=0, imem_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage sitting directly in front of InstructionMemory.
//   Owns the program counter, captures the instruction returned by the memory
//   into an IF/ID register and hands it to decode over a valid/ready
//   handshake. Handles decode back-pressure, branch/jump redirects (which
//   flush the IF/ID register) and HALT detection.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   HALT_OPCODE  value of ins[15:12] that marks a HALT instruction
//
// Ports
//   clk             single clock, all state updates on posedge
//   rst_n           synchronous, active-low reset
//   imem_pc         address to InstructionMemory (word-addressed)
//   imem_ins        instruction from InstructionMemory, same cycle
//   redirect_valid  branch/jump taken this cycle
//   redirect_pc     redirect target, used when redirect_valid=1
//   id_valid        IF/ID register holds a valid instruction
//   id_ready        decode accepts id_* this cycle
//   id_ins          fetched instruction
//   id_pc           PC the instruction was fetched from
//   halted          HALT has been fetched; fetch stopped
//   fetch_count     instructions fetched, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_pc,
  input  logic [15:0] imem_ins,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [15:0] id_ins,
  output logic [15:0] id_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] pc_r;
  logic [15:0] pc_nxt_s;
  logic        id_valid_r;
  logic        id_valid_nxt_s;
  logic [15:0] id_ins_r;
  logic [15:0] id_ins_nxt_s;
  logic [15:0] id_pc_r;
  logic [15:0] id_pc_nxt_s;
  logic        halted_r;
  logic        halted_nxt_s;
  logic [15:0] fetch_count_r;
  logic [15:0] fetch_count_nxt_s;

  logic        fire_s;
  logic        is_halt_s;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Fetch fires when running, the IF/ID slot is free or being drained, and no
  // redirect is pending (a redirect wins over a fetch in the same cycle).
  always_comb begin
    fire_s    = 1'b0;
    is_halt_s = 1'b0;
    if ((state_r == ST_RUN) && (!id_valid_r || id_ready) && !redirect_valid) begin
      fire_s = 1'b1;
    end else begin
      fire_s = 1'b0;
    end
    if (imem_ins[15:12] == HALT_OPCODE) begin
      is_halt_s = 1'b1;
    end else begin
      is_halt_s = 1'b0;
    end
  end

  // Next-state and next-register computation; priority redirect > fire > drain.
  always_comb begin
    state_nxt_s       = state_r;
    pc_nxt_s          = pc_r;
    id_valid_nxt_s    = id_valid_r;
    id_ins_nxt_s      = id_ins_r;
    id_pc_nxt_s       = id_pc_r;
    fetch_count_nxt_s = fetch_count_r;

    if (redirect_valid) begin
      // Flush: drop whatever decode has not taken, id_ready is irrelevant.
      pc_nxt_s       = redirect_pc;
      id_valid_nxt_s = 1'b0;
      state_nxt_s    = ST_RUN;
    end else if (fire_s) begin
      id_ins_nxt_s      = imem_ins;
      id_pc_nxt_s       = pc_r;
      id_valid_nxt_s    = 1'b1;
      fetch_count_nxt_s = sat_inc16(fetch_count_r);
      if (is_halt_s) begin
        // PC parks on the HALT so a later redirect is the only way out.
        pc_nxt_s    = pc_r;
        state_nxt_s = ST_HALTED;
      end else begin
        pc_nxt_s    = pc_r + 16'd1;
        state_nxt_s = ST_RUN;
      end
    end else if (id_valid_r && id_ready) begin
      // Accepted with nothing new behind it (e.g. the HALT itself).
      id_valid_nxt_s = 1'b0;
    end else begin
      // Stall or idle: everything holds.
      id_valid_nxt_s = id_valid_r;
    end

    case (state_nxt_s)
      ST_RUN:    halted_nxt_s = 1'b0;
      ST_HALTED: halted_nxt_s = 1'b1;
      default:   halted_nxt_s = 1'b0;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      pc_r          <= RESET_PC;
      id_valid_r    <= 1'b0;
      id_ins_r      <= 16'h0000;
      id_pc_r       <= 16'h0000;
      halted_r      <= 1'b0;
      fetch_count_r <= 16'h0000;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      id_valid_r    <= id_valid_nxt_s;
      id_ins_r      <= id_ins_nxt_s;
      id_pc_r       <= id_pc_nxt_s;
      halted_r      <= halted_nxt_s;
      fetch_count_r <= fetch_count_nxt_s;
    end
  end

  assign imem_pc     = pc_r;
  assign id_valid    = id_valid_r;
  assign id_ins      = id_ins_r;
  assign id_pc       = id_pc_r;
  assign halted      = halted_r;
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A behavioural instruction memory
//   returns {4'h1, pc[11:0]} except at a programmable HALT address. Every
//   instruction decode is expected to accept is pushed to a queue as the
//   sequence drives it; a negedge monitor pops and compares on each transfer.
//   Direct checks cover reset values, stalls, redirects, wrap and HALT.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_pc;
  logic [15:0] imem_ins;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_ins;
  logic [15:0] id_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic        halt_en;
  logic [15:0] halt_addr;

  int vectors;
  int miscompares;

  logic [31:0] exp_q[$];

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc),
    .imem_ins       (imem_ins),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_ins         (id_ins),
    .id_pc          (id_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  // Combinational instruction memory.
  assign imem_ins = (halt_en && (imem_pc == halt_addr)) ? 16'hF000 : {4'h1, imem_pc[11:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] p, input logic [15:0] i);
    exp_q.push_back({p, i});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, {15'd0, id_valid}, 16'd0);
    chk({tag, "_halted"}, {15'd0, halted}, 16'd0);
    chk({tag, "_count"}, fetch_count, 16'd0);
    chk({tag, "_imem_pc"}, imem_pc, 16'h0000);
    chk({tag, "_id_ins"}, id_ins, 16'h0000);
    chk({tag, "_id_pc"}, id_pc, 16'h0000);
  endtask

  // Scoreboard monitor: a transfer happens at the next posedge when decode
  // is ready, the register is valid and no flush is in progress.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && id_valid && id_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 16'(exp_q.size()), 16'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", id_pc, e[31:16]);
        chk("sb_ins", id_ins, e[15:0]);
      end
    end
  end

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    halt_en        = 1'b0;
    halt_addr      = 16'd5;

    tick();
    tick();
    chk_reset("rst");

    // 1. Stream
    rst_n    = 1'b1;
    id_ready = 1'b1;
    tick();
    chk("s_valid0", {15'd0, id_valid}, 16'd1);
    chk("s_pc0", id_pc, 16'd0);
    chk("s_ins0", id_ins, 16'h1000);
    push(16'd0, 16'h1000);
    tick();
    chk("s_pc1", id_pc, 16'd1);
    chk("s_ins1", id_ins, 16'h1001);
    push(16'd1, 16'h1001);
    tick();
    chk("s_pc2", id_pc, 16'd2);
    chk("s_ins2", id_ins, 16'h1002);

    // 2. Stall at id_pc=2
    id_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("st_pc", id_pc, 16'd2);
      chk("st_ins", id_ins, 16'h1002);
      chk("st_imem", imem_pc, 16'd3);
      chk("st_count", fetch_count, 16'd3);
      chk("st_valid", {15'd0, id_valid}, 16'd1);
    end
    id_ready = 1'b1;
    push(16'd2, 16'h1002);
    tick();
    chk("rel_pc", id_pc, 16'd3);
    chk("rel_ins", id_ins, 16'h1003);

    // 3. Redirect during a stall
    id_ready = 1'b0;
    tick();
    chk("st2_pc", id_pc, 16'd3);
    chk("st2_count", fetch_count, 16'd4);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0010;
    tick();
    chk("rd_valid", {15'd0, id_valid}, 16'd0);
    chk("rd_imem", imem_pc, 16'h0010);
    chk("rd_count", fetch_count, 16'd4);
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    tick();
    chk("rd_valid1", {15'd0, id_valid}, 16'd1);
    chk("rd_pc1", id_pc, 16'h0010);
    chk("rd_ins1", id_ins, 16'h1010);
    chk("rd_count1", fetch_count, 16'd5);
    push(16'h0010, 16'h1010);
    tick();
    chk("rd_pc2", id_pc, 16'h0011);

    // 4. Wrap: redirect to 16'hFFFF while ready (held 0x11 is discarded)
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    tick();
    chk("wr_valid", {15'd0, id_valid}, 16'd0);
    chk("wr_imem", imem_pc, 16'hFFFF);
    redirect_valid = 1'b0;
    tick();
    chk("wr_pc0", id_pc, 16'hFFFF);
    chk("wr_ins0", id_ins, 16'h1FFF);
    chk("wr_imem0", imem_pc, 16'h0000);
    push(16'hFFFF, 16'h1FFF);
    tick();
    chk("wr_pc1", id_pc, 16'h0000);
    chk("wr_imem1", imem_pc, 16'h0001);
    push(16'h0000, 16'h1000);

    // 5. Halt at pc=5
    halt_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("h_pc", id_pc, 16'(k));
      push(16'(k), {4'h1, 12'(k)});
    end
    tick();
    chk("h_pc5", id_pc, 16'd5);
    chk("h_ins5", id_ins, 16'hF000);
    chk("h_halted", {15'd0, halted}, 16'd1);
    chk("h_imem", imem_pc, 16'd5);
    chk("h_count", fetch_count, 16'd13);
    id_ready = 1'b0;
    tick();
    chk("hs_valid", {15'd0, id_valid}, 16'd1);
    chk("hs_pc", id_pc, 16'd5);
    chk("hs_imem", imem_pc, 16'd5);
    chk("hs_count", fetch_count, 16'd13);
    id_ready = 1'b1;
    push(16'd5, 16'hF000);
    tick();
    chk("ha_valid", {15'd0, id_valid}, 16'd0);
    chk("ha_halted", {15'd0, halted}, 16'd1);
    chk("ha_imem", imem_pc, 16'd5);
    chk("ha_count", fetch_count, 16'd13);
    tick();
    chk("ha2_valid", {15'd0, id_valid}, 16'd0);
    chk("ha2_count", fetch_count, 16'd13);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    tick();
    chk("hr_halted", {15'd0, halted}, 16'd0);
    chk("hr_valid", {15'd0, id_valid}, 16'd0);
    chk("hr_imem", imem_pc, 16'h0000);
    redirect_valid = 1'b0;
    tick();
    chk("hr_pc", id_pc, 16'h0000);
    chk("hr_valid1", {15'd0, id_valid}, 16'd1);
    chk("hr_count", fetch_count, 16'd14);
    push(16'h0000, 16'h1000);

    // 6. Reset mid-stall
    tick();
    chk("ms_pc", id_pc, 16'd1);
    id_ready = 1'b0;
    tick();
    chk("ms_pc2", id_pc, 16'd1);
    chk("ms_imem", imem_pc, 16'd2);
    rst_n = 1'b0;
    tick();
    chk_reset("rst_stall");

    // Reset mid-HALT
    rst_n     = 1'b1;
    id_ready  = 1'b1;
    halt_addr = 16'd1;
    tick();
    chk("mh_pc0", id_pc, 16'd0);
    push(16'd0, 16'h1000);
    tick();
    chk("mh_halted", {15'd0, halted}, 16'd1);
    chk("mh_ins", id_ins, 16'hF000);
    id_ready = 1'b0;
    rst_n    = 1'b0;
    tick();
    chk_reset("rst_halt");
    rst_n   = 1'b1;
    halt_en = 1'b0;
    tick();
    @(negedge clk);
    chk("sb_left", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
